// File: rtl/buf_op_pipe_if.sv
// buf_op_pipe_if: operand-side and result-side valid/ready bundle for buf_op_pipe.
// master = operand source / result consumer, slave = buf_op_pipe.
interface buf_op_pipe_if #(
    parameter int unsigned W = 8
);
    localparam int unsigned SHW = $clog2(W);

    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_op;
    logic [W-1:0]   in_a;
    logic           in_b;
    logic [SHW-1:0] in_shamt;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;

    modport master (
        output in_valid, in_op, in_a, in_b, in_shamt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_shamt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/buf_op_pipe.sv
// buf_op_pipe: selectable single-op datapath (ZX/SHL/ADD/INV), STAGES-deep
// valid/ready pipeline emitting ~OP(a,b), plus a saturating completion counter.
// Optional feature macro: BUF_OP_SAT_EN (ADD and SHL saturate to all-ones).
module buf_op_pipe #(
    parameter int unsigned W      = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned ADD_K  = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    buf_op_pipe_if.slave     bus,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [W-1:0] ADD_K_W = W'(ADD_K);

    typedef enum logic [1:0] {
        OP_ZX  = 2'd0,
        OP_SHL = 2'd1,
        OP_ADD = 2'd2,
        OP_INV = 2'd3
    } op_e;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [W-1:0]      data_q [STAGES];
    logic [W-1:0]      data_d [STAGES];
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic [W-1:0]      mid_c;
    logic              adv_c;
    logic              complete_c;
`ifdef BUF_OP_SAT_EN
    logic [2*W-1:0]    wide_c;
    logic [W:0]        sum_c;
`endif

    // Operation select: mid = OP(a, b) feeding stage 0.
    always_comb begin
        mid_c = '0;
`ifdef BUF_OP_SAT_EN
        wide_c = '0;
        sum_c  = '0;
`endif
        unique case (op_e'(bus.in_op))
            OP_ZX:  mid_c = W'(bus.in_b);
            OP_SHL: begin
`ifdef BUF_OP_SAT_EN
                // any bit pushed past the MSB forces all-ones
                wide_c = {W'(0), bus.in_a} << bus.in_shamt;
                mid_c  = (|wide_c[2*W-1:W]) ? '1 : wide_c[W-1:0];
`else
                mid_c = bus.in_a << bus.in_shamt;
`endif
            end
            OP_ADD: begin
`ifdef BUF_OP_SAT_EN
                sum_c = {1'b0, bus.in_a} + {1'b0, ADD_K_W};
                mid_c = sum_c[W] ? '1 : sum_c[W-1:0];
`else
                mid_c = bus.in_a + ADD_K_W;
`endif
            end
            OP_INV: mid_c = ~bus.in_a;
        endcase
    end

    // Pipeline advance: whole pipe shifts unless the head is stalled.
    always_comb begin
        adv_c      = !(valid_q[STAGES-1] && !bus.out_ready);
        complete_c = valid_q[STAGES-1] && bus.out_ready;
        valid_d    = valid_q;
        data_d     = data_q;
        if (adv_c) begin
            valid_d[0] = bus.in_valid;
            data_d[0]  = mid_c;
            for (int unsigned s = 1; s < STAGES; s++) begin
                valid_d[s] = valid_q[s-1];
                data_d[s]  = data_q[s-1];
            end
            // inversion sits in front of the final (output) register
            data_d[STAGES-1] = ~data_d[STAGES-1];
        end
        op_count_d = op_count_q;
        if (complete_c && (op_count_q != '1)) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; reset drops in-flight work.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            op_count_q <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            op_count_q <= op_count_d;
            for (int unsigned s = 0; s < STAGES; s++) begin
                data_q[s] <= data_d[s];
            end
        end
    end

    assign bus.in_ready  = adv_c;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];
    assign op_count      = op_count_q;
endmodule
